sp_sram_arb_ctrl: RTL



---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_arb_rr.sv | 54 +++++
 rtl/sp_sram_arb_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and default geometry for the two-requester single-port SRAM arbiter.
package sram_arb_pkg;

    localparam int DEF_AW    = 9;
    localparam int DEF_DW    = 32;
    localparam int DEF_DEPTH = 512;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam logic [DEF_AW-1:0] FILL_LAST = DEF_AW'(DEF_DEPTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_INIT
    } state_t;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin picker with burst lock; owns the pointer and lock owner.
module sram_arb_rr
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [1:0] req,
    input  logic [1:0] lck,
    input  logic       adv,
    output logic [1:0] gnt
);

    logic ptr;
    logic lock_vld;
    logic lock_own;
    logic win;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (lock_vld) gnt = (lock_own == REQ1) ? 2'b10 : 2'b01;
                else          gnt = (ptr == REQ1)      ? 2'b10 : 2'b01;
            end
            default: gnt = 2'b00;
        endcase
    end

    assign win = gnt[1];

    // A lock owner that drops its request loses the lock; an unlocked beat hands priority over.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr      <= REQ0;
            lock_vld <= 1'b0;
            lock_own <= REQ0;
        end else begin
            if (lock_vld && !req[lock_own]) lock_vld <= 1'b0;
            if (adv && (gnt != 2'b00)) begin
                if (lck[win]) begin
                    lock_vld <= 1'b1;
                    lock_own <= win;
                end else begin
                    lock_vld <= 1'b0;
                    ptr      <= ~win;
                end
            end
        end
    end

endmodule

// File: rtl/sp_sram_arb_ctrl.sv
// Two-requester single-port SRAM controller with round-robin/lock arbitration and a fill engine.
// Optional per-requester grant counters are built when SRAM_ARB_CNT_EN is defined.
module sp_sram_arb_ctrl
    import sram_arb_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iReq0,
    input  logic          iWrn0,
    input  logic          iLck0,
    input  logic [AW-1:0] iAddr0,
    input  logic [DW-1:0] iWrDt0,
    output logic          oGnt0,
    output logic          oRdVld0,
    output logic [DW-1:0] oRdDt0,
    input  logic          iReq1,
    input  logic          iWrn1,
    input  logic          iLck1,
    input  logic [AW-1:0] iAddr1,
    input  logic [DW-1:0] iWrDt1,
    output logic          oGnt1,
    output logic          oRdVld1,
    output logic [DW-1:0] oRdDt1,
    input  logic          iInitStart,
    input  logic [DW-1:0] iInitDt,
    output logic          oInitBusy,
    output logic          oInitDone,
    output logic          oCsn,
    output logic          oWrn,
    output logic [AW-1:0] oAddr,
    output logic [DW-1:0] oWrDt,
`ifdef SRAM_ARB_CNT_EN
    output logic [15:0]   oGntCnt0,
    output logic [15:0]   oGntCnt1,
`endif
    input  logic [DW-1:0] iRdDt
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] fill_cnt;
    logic [DW-1:0] fill_dt;
    logic          init_done;
    logic          init_go;
    logic          rd_vld;
    logic          rd_id;
    logic [1:0]    arb_req;
    logic [1:0]    gnt;

    // A fill request outranks any pending beat in the same cycle.
    assign init_go = (state == ST_IDLE) && iInitStart;
    assign arb_req = ((state == ST_IDLE) && !iInitStart && !iRst) ? {iReq1, iReq0} : 2'b00;

    sram_arb_rr u_rr (
        .clk (iClk),
        .rst (iRst),
        .clr (init_go),
        .req (arb_req),
        .lck ({iLck1, iLck0}),
        .adv (state == ST_IDLE),
        .gnt (gnt)
    );

    always_ff @(posedge iClk) begin
        if (iRst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (iInitStart) state_nxt = ST_INIT;
            ST_INIT: if (fill_cnt == LAST_ADDR) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read tag: remembers which requester owns the data the SRAM returns next cycle.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            fill_cnt  <= '0;
            fill_dt   <= '0;
            init_done <= 1'b0;
            rd_vld    <= 1'b0;
            rd_id     <= REQ0;
        end else begin
            init_done <= (state == ST_INIT) && (fill_cnt == LAST_ADDR);
            if (init_go) begin
                fill_cnt <= '0;
                fill_dt  <= iInitDt;
            end else if (state == ST_INIT) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            rd_vld <= (gnt[0] & iWrn0) | (gnt[1] & iWrn1);
            rd_id  <= gnt[1];
        end
    end

    always_comb begin
        oCsn  = 1'b1;
        oWrn  = 1'b1;
        oAddr = '0;
        oWrDt = '0;
        if (state == ST_INIT) begin
            oCsn  = 1'b0;
            oWrn  = 1'b0;
            oAddr = fill_cnt;
            oWrDt = fill_dt;
        end else if (gnt[0]) begin
            oCsn  = 1'b0;
            oWrn  = iWrn0;
            oAddr = iAddr0;
            oWrDt = iWrDt0;
        end else if (gnt[1]) begin
            oCsn  = 1'b0;
            oWrn  = iWrn1;
            oAddr = iAddr1;
            oWrDt = iWrDt1;
        end
    end

    assign oGnt0     = gnt[0];
    assign oGnt1     = gnt[1];
    assign oRdVld0   = rd_vld && (rd_id == REQ0);
    assign oRdVld1   = rd_vld && (rd_id == REQ1);
    assign oRdDt0    = oRdVld0 ? iRdDt : '0;
    assign oRdDt1    = oRdVld1 ? iRdDt : '0;
    assign oInitBusy = (state == ST_INIT);
    assign oInitDone = init_done;

`ifdef SRAM_ARB_CNT_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    always_ff @(posedge iClk) begin
        if (iRst || init_go) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (gnt[0] && (cnt0 != 16'hFFFF)) cnt0 <= cnt0 + 16'd1;
            if (gnt[1] && (cnt1 != 16'hFFFF)) cnt1 <= cnt1 + 16'd1;
        end
    end

    assign oGntCnt0 = cnt0;
    assign oGntCnt1 = cnt1;
`endif

endmodule
